// File: rtl/systolic_input_skewer_pkg.sv
// Shared definitions for the systolic input skewer: FSM encoding, default
// array geometry and the drain-counter width helper.
package systolic_input_skewer_pkg;

    localparam int DEFAULT_LANES      = 8;
    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    // A single-lane build still needs a one-bit counter.
    function automatic int cnt_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/systolic_input_skewer_if.sv
// Beat bus between the upstream operand source and the skewer, plus the
// skewed wavefront and tile status returned to the array side.
interface systolic_input_skewer_if
    import systolic_input_skewer_pkg::*;
#(
    parameter int LANES      = DEFAULT_LANES,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

    logic                        i_valid;
    logic                        i_ready;
    logic                        i_last;
    logic                        i_flush;
    logic [LANES*DATA_WIDTH-1:0] i_data;
    logic [LANES-1:0]            o_valid;
    logic [LANES*DATA_WIDTH-1:0] o_data;
    logic                        o_busy;
    logic                        o_done;

    modport master (
        output i_valid, i_last, i_flush, i_data,
        input  i_ready, o_valid, o_data, o_busy, o_done
    );

    modport slave (
        input  i_valid, i_last, i_flush, i_data,
        output i_ready, o_valid, o_data, o_busy, o_done
    );

endinterface

// File: rtl/systolic_input_skewer_skew_lane.sv
// One lane of the skewer: a DEPTH-stage delay line carrying data and valid
// together; slots without a valid beat carry zero data.
module skew_lane #(
    parameter int DEPTH      = 1,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_flush,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic                  r_vld_p  [DEPTH];
    logic [DATA_WIDTH-1:0] r_data_p [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < DEPTH; s++) begin
                r_vld_p[s]  <= 1'b0;
                r_data_p[s] <= '0;
            end
        end else if (i_flush) begin
            for (int s = 0; s < DEPTH; s++) begin
                r_vld_p[s]  <= 1'b0;
                r_data_p[s] <= '0;
            end
        end else begin
            // stage 0 captures the accepted beat, later stages shift
            r_vld_p[0]  <= i_valid;
            r_data_p[0] <= i_valid ? i_data : '0;
            for (int s = 1; s < DEPTH; s++) begin
                r_vld_p[s]  <= r_vld_p[s-1];
                r_data_p[s] <= r_data_p[s-1];
            end
        end
    end

    assign o_valid = r_vld_p[DEPTH-1];
    assign o_data  = r_data_p[DEPTH-1];

endmodule

// File: rtl/systolic_input_skewer.sv
// Row-to-wavefront skewer: lane k delayed by k+1 cycles, with a tile FSM that
// stalls input while the final wavefront drains and then pulses o_done.
module systolic_input_skewer
    import systolic_input_skewer_pkg::*;
#(
    parameter int LANES      = DEFAULT_LANES,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    systolic_input_skewer_if.slave bus
);

    localparam int               CNT_W    = cnt_width(LANES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LANES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic             w_ready;
    logic             w_accept;

    assign w_ready     = (r_state != ST_DRAIN) && !bus.i_flush;
    assign w_accept    = bus.i_valid && w_ready;
    assign bus.i_ready = w_ready;
    assign bus.o_busy  = (r_state != ST_IDLE);
    assign bus.o_done  = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else if (bus.i_flush) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_STREAM: begin
                    if (w_accept) begin
                        if (!bus.i_last) begin
                            r_state <= ST_STREAM;
                        end else if (LANES == 1) begin
                            // the only lane emits on the next cycle, nothing to drain
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_DRAIN;
                            r_cnt   <= CNT_LOAD;
                        end
                    end
                end
                ST_DRAIN: begin
                    // leaving on the cycle the last lane emits its final beat
                    if (r_cnt <= CNT_ONE) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    genvar k;
    for (k = 0; k < LANES; k++) begin : g_lane
        skew_lane #(
            .DEPTH      (k + 1),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_flush (bus.i_flush),
            .i_valid (w_accept),
            .i_data  (bus.i_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .o_valid (bus.o_valid[k]),
            .o_data  (bus.o_data[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_systolic_input_skewer.sv
// Directed bench for the skewer: a 4-lane instance for the tile scenarios and
// a 1-lane instance for the no-drain corner.
module tb_systolic_input_skewer;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    systolic_input_skewer_if #(.LANES(4), .DATA_WIDTH(8)) b4 ();
    systolic_input_skewer_if #(.LANES(1), .DATA_WIDTH(8)) b1 ();

    systolic_input_skewer #(.LANES(4), .DATA_WIDTH(8)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4.slave)
    );

    systolic_input_skewer #(.LANES(1), .DATA_WIDTH(8)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic v, input logic last, input logic flush, input logic [31:0] d);
        b4.i_valid = v;
        b4.i_last  = last;
        b4.i_flush = flush;
        b4.i_data  = d;
    endtask

    task automatic drive1(input logic v, input logic last, input logic flush, input logic [7:0] d);
        b1.i_valid = v;
        b1.i_last  = last;
        b1.i_flush = flush;
        b1.i_data  = d;
    endtask

    task automatic out4(input string tag, input logic [3:0] v, input logic [31:0] d,
                        input logic rdy, input logic dn, input logic bsy);
        chk({tag, ".valid"}, 32'(b4.o_valid), 32'(v));
        chk({tag, ".data"},  b4.o_data,       d);
        chk({tag, ".ready"}, 32'(b4.i_ready), 32'(rdy));
        chk({tag, ".done"},  32'(b4.o_done),  32'(dn));
        chk({tag, ".busy"},  32'(b4.o_busy),  32'(bsy));
    endtask

    // Single-beat tile {0x11,0x22,0x33,0x44}: lane k = 0x11*(k+1) at cycle t+1+k.
    task automatic single_beat(input string tag);
        tick();
        drive4(1'b1, 1'b1, 1'b0, 32'h4433_2211);
        #1;
        chk({tag, ".rdy_t"}, 32'(b4.i_ready), 32'd1);
        tick();
        drive4(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        out4({tag, ".t1"}, 4'b0001, 32'h0000_0011, 1'b0, 1'b0, 1'b1);
        tick(); #1;
        out4({tag, ".t2"}, 4'b0010, 32'h0000_2200, 1'b0, 1'b0, 1'b1);
        tick(); #1;
        out4({tag, ".t3"}, 4'b0100, 32'h0033_0000, 1'b0, 1'b0, 1'b1);
        tick(); #1;
        out4({tag, ".t4"}, 4'b1000, 32'h4400_0000, 1'b1, 1'b1, 1'b0);
        tick(); #1;
        out4({tag, ".t5"}, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive4(1'b0, 1'b0, 1'b0, 32'h0);
        drive1(1'b0, 1'b0, 1'b0, 8'h0);

        // reset state and idle after release
        #12;
        out4("rst", 4'b0000, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("rst.l1_ready", 32'(b1.i_ready), 32'd1);
        chk("rst.l1_valid", 32'(b1.o_valid), 32'd0);
        #10 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            out4("idle", 4'b0000, 32'h0, 1'b1, 1'b0, 1'b0);
        end

        single_beat("single");

        // 3-beat tile B0, bubble, B1, B2(last)
        tick();
        drive4(1'b1, 1'b0, 1'b0, 32'h0403_0201);
        tick();
        drive4(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        out4("bub.s1", 4'b0001, 32'h0000_0001, 1'b1, 1'b0, 1'b1);
        tick();
        drive4(1'b1, 1'b0, 1'b0, 32'h1413_1211);
        #1;
        out4("bub.s2", 4'b0010, 32'h0000_0200, 1'b1, 1'b0, 1'b1);
        tick();
        drive4(1'b1, 1'b1, 1'b0, 32'h2423_2221);
        #1;
        out4("bub.s3", 4'b0101, 32'h0003_0011, 1'b1, 1'b0, 1'b1);
        tick();
        drive4(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        out4("bub.s4", 4'b1011, 32'h0400_1221, 1'b0, 1'b0, 1'b1);
        tick(); #1;
        out4("bub.s5", 4'b0110, 32'h0013_2200, 1'b0, 1'b0, 1'b1);
        tick(); #1;
        out4("bub.s6", 4'b1100, 32'h1423_0000, 1'b0, 1'b0, 1'b1);
        tick(); #1;
        out4("bub.s7", 4'b1000, 32'h2400_0000, 1'b1, 1'b1, 1'b0);

        // beat offered during DRAIN is dropped; next tile taken in the done cycle
        tick();
        drive4(1'b1, 1'b1, 1'b0, 32'h0D0C_0B0A);
        tick();
        drive4(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
        #1;
        out4("drop.t1", 4'b0001, 32'h0000_000A, 1'b0, 1'b0, 1'b1);
        tick();
        drive4(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        out4("drop.t2", 4'b0010, 32'h0000_0B00, 1'b0, 1'b0, 1'b1);
        tick(); #1;
        out4("drop.t3", 4'b0100, 32'h000C_0000, 1'b0, 1'b0, 1'b1);
        tick();
        drive4(1'b1, 1'b1, 1'b0, 32'h3433_3231);
        #1;
        out4("drop.t4", 4'b1000, 32'h0D00_0000, 1'b1, 1'b1, 1'b0);
        tick();
        drive4(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        out4("drop.t5", 4'b0001, 32'h0000_0031, 1'b0, 1'b0, 1'b1);
        tick(); #1;
        out4("drop.t6", 4'b0010, 32'h0000_3200, 1'b0, 1'b0, 1'b1);
        tick(); #1;
        tick(); #1;
        out4("drop.t8", 4'b1000, 32'h3400_0000, 1'b1, 1'b1, 1'b0);

        // flush two cycles into a streaming tile
        tick();
        drive4(1'b1, 1'b0, 1'b0, 32'h5453_5251);
        tick();
        drive4(1'b1, 1'b0, 1'b0, 32'h6463_6261);
        tick();
        drive4(1'b1, 1'b0, 1'b1, 32'h7473_7271);
        #1;
        chk("flush.ready_f", 32'(b4.i_ready), 32'd0);
        chk("flush.valid_f", 32'(b4.o_valid), 32'b0011);
        tick();
        drive4(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        out4("flush.f1", 4'b0000, 32'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            out4("flush.after", 4'b0000, 32'h0, 1'b1, 1'b0, 1'b0);
        end
        single_beat("postflush");

        // asynchronous reset in the middle of DRAIN
        tick();
        drive4(1'b1, 1'b1, 1'b0, 32'h8887_8685);
        tick();
        drive4(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        #1;
        out4("arst.pre", 4'b0010, 32'h0000_8600, 1'b0, 1'b0, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        out4("arst.now", 4'b0000, 32'h0, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            out4("arst.after", 4'b0000, 32'h0, 1'b1, 1'b0, 1'b0);
        end

        // single-lane build: no DRAIN, o_done with the lane output
        tick();
        drive1(1'b1, 1'b1, 1'b0, 8'h5C);
        #1;
        chk("l1.ready_t", 32'(b1.i_ready), 32'd1);
        tick();
        drive1(1'b0, 1'b0, 1'b0, 8'h0);
        #1;
        chk("l1.valid_t1", 32'(b1.o_valid), 32'd1);
        chk("l1.data_t1",  32'(b1.o_data),  32'h5C);
        chk("l1.done_t1",  32'(b1.o_done),  32'd1);
        chk("l1.ready_t1", 32'(b1.i_ready), 32'd1);
        chk("l1.busy_t1",  32'(b1.o_busy),  32'd0);
        tick(); #1;
        chk("l1.valid_t2", 32'(b1.o_valid), 32'd0);
        chk("l1.data_t2",  32'(b1.o_data),  32'h0);
        chk("l1.done_t2",  32'(b1.o_done),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_input_skewer.md
# systolic_input_skewer

Turns a parallel row of LANES operands into the diagonal wavefront that a systolic PE array expects. Lane k is delayed by k+1 cycles, and each lane carries its own valid. Beats arrive in tiles that end with i_last. A small FSM blocks new input while the final wavefront of a tile drains, then pulses o_done. The block sits directly upstream of the array's per-row delay lines and PE column inputs.

## Interface
- LANES, 8: number of lanes (rows fed); must be ≥1.
- DATA_WIDTH, 8: bits per lane.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  input beat valid.
- i_ready  out  1  beat accepted when i_valid && i_ready.
- i_last  in  1  accepted beat is the last of its tile.
- i_flush  in  1  synchronous clear; has priority over every other input.
- i_data  in  LANES*DATA_WIDTH  lane k is i_data[k*DATA_WIDTH +: DATA_WIDTH].
- o_valid  out  LANES  per-lane output valid.
- o_data  out  LANES*DATA_WIDTH  skewed lanes; same packing as i_data.
- o_busy  out  1  high in STREAM or DRAIN.
- o_done  out  1  one-cycle pulse when a tile has fully left the block.

## Operation
- States are IDLE, STREAM and DRAIN.
  - IDLE → STREAM on an accepted beat with i_last=0.
  - IDLE or STREAM → DRAIN on an accepted beat with i_last=1.
  - DRAIN → IDLE after the drain count expires.
- i_ready = (state != DRAIN) && !i_flush.
- A beat offered while i_ready=0 is dropped. It has no effect on state or data, and it is the upstream block's fault.
- Each lane is an independent delay of k+1 stages. Stage data is loaded only when the accepted valid is high. When valid is low, zero is shifted in, so o_data of a lane whose o_valid is low is always 0.
- Bubbles: a beat that is not accepted in STREAM shifts an invalid (zero) slot through every lane. The skew is preserved per beat.
- Drain count: the counter is loaded with LANES-1 on acceptance of the last beat and decrements each DRAIN cycle. At 0 the FSM returns to IDLE and o_done is registered high for that one cycle.
- LANES=1: DRAIN is skipped. The last beat goes straight to IDLE, and o_done fires on the lane's output cycle.
- i_flush: all delay stages, o_valid and o_data clear to 0, the counter clears, and the state goes to IDLE on the next edge. No o_done is generated for an aborted tile.
- Reset values: o_valid=0, o_data=0, o_busy=0, o_done=0, i_ready=1, state=IDLE, counter=0.

## Timing
- A beat accepted in cycle t appears on lane k in cycle t+k+1, with o_valid[k]=1. All outputs are registered.
- Last beat accepted at t:
  - DRAIN covers cycles t+1 … t+LANES-1.
  - o_done=1 and i_ready=1 in cycle t+LANES, the same cycle lane LANES-1 emits its final valid.
  - A new tile may be accepted in cycle t+LANES. Its lane-0 output lands at t+LANES+1, so there is no overlap.
- Back-to-back tiles therefore have a LANES-1 cycle gap, which is the minimum.
- Flush asserted in cycle f: all outputs are 0 from f+1. i_ready is 0 during f and 1 again from f+1.
- Reset asserted mid-tile: all outputs go to their reset values immediately (asynchronous reset). A tile in flight is lost without an o_done.

## Structure
- Shared package/header holds:
  - FSM state encoding: IDLE=2'd0, STREAM=2'd1, DRAIN=2'd2.
  - Default LANES and DATA_WIDTH, common to the array top.
- Counter width is $clog2(LANES), with a minimum of 1.
- One sub-module, skew_lane:
  - Parameterised DEPTH and DATA_WIDTH.
  - Ports: clk, rst_n, i_flush, i_valid, i_data, o_valid, o_data.
  - Instanced with DEPTH=k+1 in a generate loop.
- The FSM, counter and ready/done logic live in the top.

## Test plan
- Reset release with i_valid=0: all outputs 0, i_ready=1, o_done never asserts.
- LANES=4, single-beat tile at t=10 with i_data lanes {0x11,0x22,0x33,0x44} and i_last=1:
  - lane k = 0x11·(k+1) with o_valid[k]=1 in cycle 11+k.
  - o_done=1 in cycle 14; i_ready=0 in cycles 11–13.
- LANES=4, 3-beat tile with a one-cycle bubble between beats 1 and 2:
  - each lane shows the sequence B0, 0, B1, B2 with matching o_valid pattern 1,0,1,1.
  - o_done comes 4 cycles after the last beat.
- Beat offered during DRAIN with data 0xFF on all lanes: it is dropped, with no valid and no data on any lane; the next tile is accepted in the done cycle and its lane 0 appears one cycle later.
- i_flush asserted 2 cycles into a streaming tile: all o_valid and o_data are 0 from the next cycle, no o_done is seen, and a new tile then behaves as in scenario 2.
- rst_n pulsed low mid-DRAIN (asynchronously, between edges): outputs clear immediately, no o_done; LANES=1 build completes a single beat at t with o_done and o_valid[0] both at t+1.
